// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I front-end constants, fetch FSM state type and helpers.
// The HALT state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;
`endif

  // Sequential next fetch address; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {instr, pc} buffer between instruction memory and decode.
// Slot 0 is always the head, so the read port comes straight from a register.
module fetch_fifo
  import rv32i_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [ILEN+XLEN-1:0] i_data,
  output logic [ILEN+XLEN-1:0] o_head,
  output logic [1:0]           o_count
);

  logic [ILEN+XLEN-1:0] r_slot0;
  logic [ILEN+XLEN-1:0] r_slot1;
  logic [1:0]           r_count;
  logic                 w_pop;
  logic                 w_push;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
  assign o_head  = r_slot0;
  assign o_count = r_count;

  // Shift-style storage update; clear only empties, data is don't-care when empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else if (i_clr) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_slot0 <= i_data;
          else                 r_slot1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_slot0 <= i_data;
          end else begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_data;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, credit-limited instruction-memory requests,
// in-order response tagging and redirect handling with stale-response dropping.
// Optional: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets
// (adds o_if_misalign and the HALT state); otherwise targets are word-aligned.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  output logic [ILEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  input  logic            i_if_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            o_if_misalign
`endif
);

  fetch_state_e         r_state;
  fetch_state_e         w_state_nxt;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      w_pc_nxt;
  logic [XLEN-1:0]      r_tag0;
  logic [XLEN-1:0]      r_tag1;
  logic [XLEN-1:0]      w_target;
  logic [1:0]           r_outst;
  logic [1:0]           w_outst_nxt;
  logic [1:0]           r_drop;
  logic [1:0]           w_drop_nxt;
  logic [1:0]           w_fifo_count;
  logic [ILEN+XLEN-1:0] w_fifo_head;
  logic [2:0]           w_credit_used;
  logic                 w_fetching;
  logic                 w_grant;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop_rsp;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_mis_nxt;
  assign w_target      = i_redirect_pc;
  assign o_if_misalign = r_misalign;
`else
  assign w_target = i_redirect_pc & 32'hFFFF_FFFC;
`endif

  // A slot freed by a same-cycle pop counts as free, allowing back-to-back delivery.
  assign w_fetching    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_if_valid    = (w_fifo_count != 2'd0) && !i_redirect;
  assign w_pop         = o_if_valid && i_if_ready;
  assign w_credit_used = {1'b0, r_outst} + {1'b0, w_fifo_count} - {2'b00, w_pop};
  assign o_imem_req    = w_fetching && !i_redirect && (w_credit_used < 3'd2);
  assign w_grant       = o_imem_req && i_imem_gnt;
  assign w_drop_rsp    = i_imem_rvalid && (r_drop != 2'd0);
  assign w_push        = i_imem_rvalid && (r_drop == 2'd0) && !i_redirect;
  assign w_outst_nxt   = r_outst + {1'b0, w_grant} - {1'b0, i_imem_rvalid};
  assign o_imem_addr   = r_pc;
  assign o_if_instr    = w_fifo_head[ILEN+XLEN-1:XLEN];
  assign o_if_pc       = w_fifo_head[XLEN-1:0];

  // Next state, PC and drop count; a redirect overrides every other event.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop - {1'b0, w_drop_rsp};
`ifdef FETCH_MISALIGN_TRAP_EN
    w_mis_nxt   = r_misalign;
`endif
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      ST_DRAIN: begin
        if (w_drop_nxt == 2'd0) w_state_nxt = ST_RUN;
        else                    w_state_nxt = ST_DRAIN;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_HALT:  w_state_nxt = ST_HALT;
`endif
      default:  w_state_nxt = ST_BOOT;
    endcase
    if (i_redirect) begin
      w_pc_nxt   = w_target;
      w_drop_nxt = w_outst_nxt;
      if (w_outst_nxt != 2'd0) w_state_nxt = ST_DRAIN;
      else                     w_state_nxt = ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (i_redirect_pc[1:0] != 2'b00) begin
        w_state_nxt = ST_HALT;
        w_mis_nxt   = 1'b1;
      end else begin
        w_mis_nxt   = 1'b0;
      end
`endif
    end else begin
      if (w_grant) w_pc_nxt = pc_incr(r_pc);
      else         w_pc_nxt = r_pc;
    end
  end

  // FSM, PC, in-flight and drop counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_outst <= 2'd0;
      r_drop  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_outst <= w_outst_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Address tags of in-flight requests, oldest in r_tag0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag0 <= '0;
      r_tag1 <= '0;
    end else begin
      case ({w_grant, i_imem_rvalid})
        2'b10: begin
          if (r_outst == 2'd0) r_tag0 <= r_pc;
          else                 r_tag1 <= r_pc;
        end
        2'b01: r_tag0 <= r_tag1;
        2'b11: begin
          if (r_outst == 2'd1) begin
            r_tag0 <= r_pc;
          end else begin
            r_tag0 <= r_tag1;
            r_tag1 <= r_pc;
          end
        end
        default: r_tag0 <= r_tag0;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag, cleared by the next aligned redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_misalign <= 1'b0;
    else          r_misalign <= w_mis_nxt;
  end
`endif

  fetch_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({i_imem_rdata, r_tag0}),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed stimulus checked every cycle against a
// queue-level fetch model (in-flight list with stale marks, decode buffer list).
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_misalign;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;
  logic [31:0] inf_pc[$];
  bit          inf_stale[$];
  logic [31:0] fq_pc[$];
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          cyc;
  int          lat;
  int          p_rsp;

  // per-cycle DUT samples for hand-computed expectations
  bit          s_req[64];
  bit          s_valid[64];
  bit          s_mis[64];
  logic [31:0] s_addr[64];
  logic [31:0] s_pc[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_if_valid    (if_valid),
    .o_if_instr    (if_instr),
    .o_if_pc       (if_pc),
    .i_if_ready    (if_ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_if_misalign (if_misalign)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign if_misalign = 1'b0;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_3C3C) + {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    if_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_addr.delete(); mem_due.delete();
    inf_pc.delete(); inf_stale.delete(); fq_pc.delete();
    m_pc = 32'h0; m_halt = 1'b0; m_mis = 1'b0; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 32'h0);
    chk("rst_valid", if_valid, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", if_misalign, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: memory answers, compare at negedge, advance model, return at posedge+1.
  task automatic cycle();
    bit          exp_req, exp_valid, grant, pop, rsp;
    int          used;
    logic [31:0] rsp_addr;
    rsp = 1'b0;
    if (mem_addr.size() > 0 && mem_due[0] <= cyc && int'($urandom_range(99)) < p_rsp) rsp = 1'b1;
    imem_rvalid = rsp;
    imem_rdata  = 32'h0;
    if (rsp) begin
      rsp_addr = mem_addr.pop_front();
      mem_due.delete(0);
      imem_rdata = mem_word(rsp_addr);
    end
    @(negedge clk);
    exp_valid = (fq_pc.size() > 0) && !redirect && !m_halt;
    pop       = exp_valid && if_ready;
    // credits: in flight plus buffered, where an entry leaving this cycle is free
    used      = inf_pc.size() + fq_pc.size() - (pop ? 1 : 0);
    exp_req   = (cyc != 0) && !m_halt && !redirect && (used < 2);
    if (cyc < 64) begin
      s_req[cyc] = imem_req; s_valid[cyc] = if_valid; s_mis[cyc] = if_misalign;
      s_addr[cyc] = imem_addr; s_pc[cyc] = if_pc;
    end
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, exp_valid);
    if (exp_valid) begin
      chk("if_pc", if_pc, fq_pc[0]);
      chk("if_instr", if_instr, mem_word(fq_pc[0]));
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("if_misalign", if_misalign, m_mis);
`endif
    grant = exp_req && imem_gnt;
    if (pop) fq_pc.delete(0);
    if (rsp && inf_pc.size() > 0) begin
      if (!inf_stale[0] && !redirect) fq_pc.push_back(inf_pc[0]);
      inf_pc.delete(0);
      inf_stale.delete(0);
    end
    if (grant) begin
      inf_pc.push_back(m_pc);
      inf_stale.push_back(1'b0);
      mem_addr.push_back(m_pc);
      mem_due.push_back(cyc + lat);
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      fq_pc.delete();
      foreach (inf_stale[i]) inf_stale[i] = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc   = redirect_pc;
      m_halt = (redirect_pc[1:0] != 2'b00);
      m_mis  = m_halt;
`else
      m_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    // streaming start-up: 1-cycle memory, always granted and accepted
    do_reset();
    lat = 1; p_rsp = 100;
    for (int c = 0; c < 8; c++) begin
      imem_gnt = 1'b1; if_ready = 1'b1; redirect = 1'b0;
      cycle();
    end
    chk("boot_valid2", s_valid[2], 32'h0);
    chk("boot_valid3", s_valid[3], 32'h1);
    chk("boot_pc3", s_pc[3], 32'h0);
    chk("boot_pc4", s_pc[4], 32'h4);
    chk("boot_pc5", s_pc[5], 32'h8);
    chk("boot_req0", s_req[0], 32'h0);

    // decode stall: buffer fills after two grants, then resumes in order
    do_reset();
    lat = 1; p_rsp = 100;
    for (int c = 0; c < 20; c++) begin
      imem_gnt = 1'b1; if_ready = (c >= 12); redirect = 1'b0;
      cycle();
    end
    begin
      int g;
      g = 0;
      for (int c = 0; c < 12; c++) g += s_req[c];
      chk("stall_grants", g, 32'd2);
    end
    chk("stall_req", s_req[11], 32'h0);
    chk("stall_addr", s_addr[11], 32'h8);
    chk("stall_valid", s_valid[11], 32'h1);
    chk("resume_pc12", s_pc[12], 32'h0);
    chk("resume_pc13", s_pc[13], 32'h4);
    chk("resume_pc14", s_pc[14], 32'h8);

    // redirect with two requests in flight (3-cycle memory)
    do_reset();
    lat = 3; p_rsp = 100;
    for (int c = 0; c < 14; c++) begin
      imem_gnt = 1'b1; if_ready = 1'b1;
      redirect = (c == 3); redirect_pc = 32'h0000_0100;
      cycle();
    end
    for (int c = 3; c < 9; c++) chk("drop_no_stale", s_valid[c], 32'h0);
    chk("redir_pc9", s_pc[9], 32'h100);
    chk("redir_pc10", s_pc[10], 32'h104);

    // redirect with same-cycle response, PC wrap, misaligned target
    do_reset();
    lat = 2; p_rsp = 100;
    for (int c = 0; c < 20; c++) begin
      imem_gnt = 1'b1; if_ready = 1'b1;
      redirect = (c == 3) || (c == 10) || (c == 14);
      redirect_pc = (c == 3) ? 32'hFFFF_FFFC : ((c == 10) ? 32'h0000_0102 : 32'h0000_0200);
      cycle();
    end
    chk("wrap_req4", s_req[4], 32'h1);
    chk("wrap_addr4", s_addr[4], 32'hFFFF_FFFC);
    chk("wrap_addr5", s_addr[5], 32'h0);
    chk("wrap_valid6", s_valid[6], 32'h0);
    chk("wrap_pc7", s_pc[7], 32'hFFFF_FFFC);
    chk("wrap_pc8", s_pc[8], 32'h0);
    chk("resume_addr15", s_addr[15], 32'h200);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_set", s_mis[11], 32'h1);
    chk("mis_noreq", s_req[11], 32'h0);
    chk("mis_clr", s_mis[15], 32'h0);
    chk("mis_resume_req", s_req[15], 32'h1);
`else
    chk("align_force", s_addr[11], 32'h100);
`endif

    // randomized traffic, then a reset with requests still in flight
    for (int run = 0; run < 2; run++) begin
      do_reset();
      p_rsp = 70;
      for (int c = 0; c < ((run == 0) ? 3000 : 300); c++) begin
        lat = int'($urandom_range(4, 1));
        imem_gnt = ($urandom_range(99) < 60);
        if_ready = ($urandom_range(99) < 70);
        redirect = (c > 1) && ($urandom_range(99) < 5);
        case ($urandom_range(3))
          0:       redirect_pc = $urandom & 32'hFFFF_FFFC;
          1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
          2:       redirect_pc = $urandom;
          default: redirect_pc = 32'h0000_0100 + (32'($urandom_range(15)) << 2);
        endcase
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Clk  input  1  sole clock; all state on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 ImemReq  output  1  instruction-memory request valid.
REQ-005 ImemAddr  output  32  word-aligned fetch address; equals PC.
REQ-006 ImemGnt  input  1  memory accepts request this cycle (ImemReq && ImemGnt).
REQ-007 ImemRvalid  input  1  read data valid; responses in order, at least 1 cycle after grant, never back-pressured.
REQ-008 ImemRdata  input  32  instruction word.
REQ-009 IfValid  output  1  instruction/PC pair valid to decode.
REQ-010 IfInstr  output  32  fetched instruction.
REQ-011 IfPc  output  32  address of IfInstr.
REQ-012 IfReady  input  1  decode accepts pair (IfValid && IfReady).
REQ-013 Redirect  input  1  branch/jump/trap redirect, single-cycle pulse.
REQ-014 RedirectPc  input  32  redirect target.

Function
REQ-015 FSM states BOOT, RUN, DRAIN; BOOT lasts exactly one cycle after reset release, no request, then RUN.
REQ-016 ImemReq SHALL be 1 in RUN/DRAIN when Redirect=0 and outstanding + FIFO occupancy < 2.
REQ-017 On grant, PC <= PC + 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0) and outstanding +1.
REQ-018 Each ImemRvalid decrements outstanding; non-dropped responses push {ImemRdata, tag PC} into a 2-entry FIFO.
REQ-019 IfValid = FIFO non-empty && !Redirect; pop on IfValid && IfReady; FIFO never overflows due to credit rule REQ-016.
REQ-020 Fetch-to-IfValid latency: grant cycle N, response cycle N+1 -> IfValid at N+2 (registered FIFO output).
REQ-021 Redirect has priority over all events: PC <= RedirectPc, FIFO cleared, drop count <= outstanding (including same-cycle grant, minus same-cycle response already counted as dropped), state -> DRAIN if drop count > 0 else RUN.
REQ-022 In DRAIN, requests continue at the new PC; the first drop-count responses are discarded; state -> RUN when drop count reaches 0.
REQ-023 Redirect during DRAIN SHALL add current outstanding to the drop count correctly (drop count = total outstanding).
REQ-024 Redirect in the same cycle as IfValid && IfReady: no transfer occurs (IfValid forced 0).
REQ-025 Decode stall (IfReady=0) with FIFO full SHALL hold ImemReq at 0 and PC unchanged.

Reset
REQ-026 Reset_n=0 asynchronously: PC=RESET_PC, state BOOT, outstanding=0, drop count=0, FIFO empty, ImemReq=0, IfValid=0, IfInstr=0, IfPc=0.
REQ-027 Reset mid-operation abandons in-flight requests; memory-side responses after reset are out of contract.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN: when defined, RedirectPc[1:0]!=0 sets output IfMisalign (1 bit, sticky) and state HALT (no requests, IfValid=0) until next aligned Redirect or reset.
REQ-029 Without FETCH_MISALIGN_TRAP_EN: no IfMisalign port, no HALT state; RedirectPc[1:0] forced to 2'b00.

Structure
REQ-030 Shared package rv32i_pkg holds XLEN=32, ILEN=32, fetch FSM state enum, NOP encoding 32'h0000_0013.
REQ-031 Sub-module fetch_fifo: 2-entry, 64-bit {instr, pc} FIFO with synchronous clear; all other logic in instr_fetch.

Verification
REQ-032 Reset release, ImemGnt=1, 1-cycle memory, IfReady=1 -> IfPc sequence 0x0,0x4,0x8 on consecutive cycles, first IfValid 3 cycles after reset release.
REQ-033 IfReady=0 for 10 cycles -> exactly 2 grants, FIFO full, ImemReq=0, PC=0x8 held; IfReady=1 resumes in order.
REQ-034 Redirect to 0x100 with 2 outstanding -> both stale responses dropped, next IfPc=0x100 then 0x104.
REQ-035 Redirect in same cycle as grant and response -> no stale instruction reaches decode; drop count exactly matches.
REQ-036 PC=0xFFFF_FFFC grant -> next ImemAddr=0x0.
REQ-037 With FETCH_MISALIGN_TRAP_EN, Redirect to 0x102 -> IfMisalign=1, ImemReq=0; Redirect to 0x200 -> fetch resumes at 0x200; without macro, 0x102 fetches 0x100.
